// File: rtl/shift_serializer_ctrl.sv
// ============================================================================
// Module      : shift_serializer_ctrl
// Description : Parallel-to-serial frame shifter with DIV-cycle bit timing.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_serializer_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BCW-1:0] c_bit_last = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] c_div_last = DCW'(DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             order_q, order_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0]   div_cnt_q, div_cnt_d;

    logic             in_ready_q, in_ready_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_accept;
    logic             w_shift_next;

    assign w_accept = in_valid & in_ready_q;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        order_d   = order_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;

        if (state_q == ST_SHIFT) begin
            if (div_cnt_q == c_div_last) begin
                div_cnt_d = '0;
                sreg_d    = order_q ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};
                if (bit_cnt_q == c_bit_last) begin
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end else begin
                div_cnt_d = div_cnt_q + DCW'(1);
            end
        end

        // A load overrides the frame-end transition, giving gapless reloads.
        if (w_accept) begin
            sreg_d    = in_data;
            order_d   = msb_first;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            state_d   = ST_SHIFT;
        end

        // Outputs are decoded from next state so they leave the block as flops.
        w_shift_next  = (state_d == ST_SHIFT);
        busy_d        = w_shift_next;
        ser_valid_d   = w_shift_next;
        ser_out_d     = w_shift_next & (order_d ? sreg_d[WIDTH-1] : sreg_d[0]);
        frame_start_d = w_shift_next & (bit_cnt_d == '0);
        done_d        = w_shift_next & (bit_cnt_d == c_bit_last) & (div_cnt_d == c_div_last);
        in_ready_d    = ~w_shift_next | done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sreg_q        <= '0;
            order_q       <= 1'b0;
            bit_cnt_q     <= '0;
            div_cnt_q     <= '0;
            in_ready_q    <= 1'b1;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            order_q       <= order_d;
            bit_cnt_q     <= bit_cnt_d;
            div_cnt_q     <= div_cnt_d;
            in_ready_q    <= in_ready_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: doc/shift_serializer_ctrl.md
SHIFT_SERIALIZER_CTRL -- requirements
Module: shift_serializer_ctrl

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the frame width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter DIV, default 4, giving the clock cycles per serial bit (legal range 1..256).

Interface
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 in_valid  input  1  upstream has a parallel word on in_data.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_data  input  WIDTH  parallel word to serialize.
REQ-009 msb_first  input  1  bit order: 1 = MSB first (shift left), 0 = LSB first (shift right); sampled only at accept.
REQ-010 ser_out  output  1  current serial bit.
REQ-011 ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-012 frame_start  output  1  high only during the cycles of bit 0 of each frame.
REQ-013 busy  output  1  a frame is in progress.
REQ-014 done  output  1  high only in the final cycle of a frame.

Function
REQ-015 The block SHALL have two states: IDLE and SHIFT.
REQ-016 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-017 On accept, the block SHALL load in_data into a WIDTH-bit shift register and capture msb_first.
- bit_cnt <= 0, div_cnt <= 0, state <= SHIFT.
REQ-018 in_ready SHALL be 1 in IDLE, and 1 in SHIFT only when done=1; otherwise it SHALL be 0.
REQ-019 Upstream SHALL hold in_data stable while in_valid=1 and in_ready=0.
- in_valid during a frame SHALL NOT alter the shift register or the captured bit order.
REQ-020 In SHIFT, ser_valid and busy SHALL be 1.
- ser_out = shift register [WIDTH-1] if the captured order is MSB first, else [0].
REQ-021 In IDLE, ser_valid=0, busy=0, ser_out=0, frame_start=0 and done=0.
REQ-022 div_cnt SHALL count 0..DIV-1 in SHIFT.
REQ-023 When div_cnt=DIV-1, the block SHALL act as follows:
- Shift by one: left with 0 fill for MSB first, right with 0 fill for LSB first.
- bit_cnt increments and div_cnt wraps to 0.
REQ-024 done SHALL be 1 when state=SHIFT, bit_cnt=WIDTH-1 and div_cnt=DIV-1.
REQ-025 At the edge ending a done cycle, the block SHALL go to IDLE, or reload and stay in SHIFT if an accept occurs.
- A reload gives gapless back-to-back frames.
REQ-026 frame_start SHALL be 1 when state=SHIFT and bit_cnt=0.
REQ-027 The first bit SHALL appear on ser_out in the cycle after accept.
- Each bit SHALL be held for exactly DIV cycles.
- A frame SHALL last exactly WIDTH*DIV cycles.
REQ-028 With DIV=1, div_cnt SHALL stay 0 and a shift SHALL occur every cycle.
REQ-029 bit_cnt SHALL be wide enough to hold WIDTH-1.
- bit_cnt SHALL never exceed WIDTH-1.
REQ-030 All outputs SHALL be functions of registered state only, with no combinational path from inputs.
- in_ready depends only on state and the counters.

Reset
REQ-031 When rst=1 at a rising edge, the block SHALL set state=IDLE, shift register=0, bit_cnt=0, div_cnt=0 and the captured order=0.
- Resulting outputs: in_ready=1, ser_out=0, ser_valid=0, frame_start=0, busy=0, done=0.
REQ-032 rst SHALL take priority over an accept in the same cycle; that word SHALL be dropped.
REQ-033 rst during SHIFT SHALL abort the frame with no done pulse.
- The block SHALL be in IDLE on the next cycle.

Verification
REQ-034 WIDTH=8, DIV=1, msb_first=0, accept 0xA5 -> ser_out over 8 cycles = 1,0,1,0,0,1,0,1.
- frame_start on cycle 1 only; done on cycle 8; busy low on cycle 9.
REQ-035 WIDTH=8, DIV=4, msb_first=1, accept 0xC3 -> ser_out = 1,1,0,0,0,0,1,1, each bit held 4 cycles.
- 32 cycles with ser_valid=1; exactly one done pulse.
REQ-036 Back-to-back, DIV=1: in_valid held high with 0x0F then 0xF0 -> second accept in the done cycle of frame 1.
- 16 consecutive ser_valid cycles; frame_start at cycles 1 and 9.
REQ-037 Busy stall: 0x55 accepted, then in_valid=1 with in_data=0xFF mid-frame -> in_ready=0 and frame 1 bits unchanged.
- 0xFF is accepted only in the done cycle.
REQ-038 rst=1 at bit 3 of a DIV=4 frame -> next cycle: busy=0, ser_valid=0, in_ready=1, no done.
- A new accept then produces a correct full frame.
REQ-039 rst=1 and in_valid=1 on the same edge -> word dropped, block IDLE, ser_valid stays 0.
